// File: rtl/msg_parser_pkg.sv
// Shared types and constants for the message parser.
package msg_parser_pkg;

  localparam int BYTE_W        = 8;
  localparam int MIN_MSG_BYTES = 8;

  // ST_DONE exists only inside a beat: it marks "all N messages seen, only tlast may follow".
  typedef enum logic [2:0] {
    ST_CNT_LO,
    ST_CNT_HI,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_DONE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/msg_byte_step.sv
// Combinational single-byte step of the packet parser; chained once per byte lane.
module msg_byte_step
  import msg_parser_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 32
) (
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  state_e            state_i,
  input  logic [15:0]       cnt_i,
  input  logic [15:0]       len_i,
  input  logic [7:0]        idx_i,
  output state_e            state_o,
  output logic [15:0]       cnt_o,
  output logic [15:0]       len_o,
  output logic [7:0]        idx_o,
  output logic              err_o,
  output logic              wr_o,
  output logic              clr_o,
  output logic              done_o
);

  logic [15:0] field;

  always_comb begin
    state_o = state_i;
    cnt_o   = cnt_i;
    len_o   = len_i;
    idx_o   = idx_i;
    err_o   = 1'b0;
    wr_o    = 1'b0;
    clr_o   = 1'b0;
    done_o  = 1'b0;
    field   = '0;
    if (en_i) begin
      unique case (state_i)
        ST_CNT_LO: begin
          cnt_o   = {8'h00, byte_i};
          state_o = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          field   = {byte_i, cnt_i[7:0]};
          cnt_o   = field;
          err_o   = (field == 16'd0);
          state_o = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_o   = {8'h00, byte_i};
          state_o = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          field = {byte_i, len_i[7:0]};
          len_o = field;
          idx_o = '0;
          if (field < 16'(MIN_MSG_BYTES) || field > 16'(MAX_MSG_BYTES)) begin
            err_o = 1'b1;
          end else begin
            clr_o   = 1'b1;
            state_o = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_o  = 1'b1;
          idx_o = idx_i + 8'd1;
          if ({8'h00, idx_o} == len_i) begin
            done_o  = 1'b1;
            cnt_o   = cnt_i - 16'd1;
            state_o = (cnt_i == 16'd1) ? ST_DONE : ST_LEN_LO;
          end
        end
        ST_DONE: err_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/msg_parser.sv
// AXI-Stream packet parser: splits {count, {length, payload}*} packets into messages,
// consuming all eight byte lanes of a beat per cycle.
module msg_parser
  import msg_parser_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 32,
  parameter int TDATA_WIDTH   = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic [TDATA_WIDTH-1:0]          s_tdata,
  input  logic [TDATA_WIDTH/BYTE_W-1:0]   s_tkeep,
  input  logic                            s_tlast,
  input  logic                            s_tuser,
  output logic                            msg_valid,
  output logic [15:0]                     msg_length,
  output logic [MAX_MSG_BYTES*BYTE_W-1:0] msg_data,
  output logic                            msg_error
);

  localparam int LANES = TDATA_WIDTH / BYTE_W;
  localparam int DW    = MAX_MSG_BYTES * BYTE_W;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            msg_valid_q, msg_valid_d, msg_error_q, msg_error_d;
  logic [15:0]     msg_length_q, msg_length_d;
  logic [DW-1:0]   msg_data_q, msg_data_d;

  logic            beat_ok;
  state_e          st_c   [LANES+1];
  logic [15:0]     cnt_c  [LANES+1];
  logic [15:0]     len_c  [LANES+1];
  logic [7:0]      idx_c  [LANES+1];
  logic            err_c  [LANES+1];
  logic            step_err [LANES];
  logic            wr_c   [LANES];
  logic            clr_c  [LANES];
  logic            done_c [LANES];

  assign s_tready = rst;
  assign beat_ok  = s_tvalid & s_tready;

  assign st_c[0]  = state_q;
  assign cnt_c[0] = cnt_q;
  assign len_c[0] = len_q;
  assign idx_c[0] = idx_q;
  assign err_c[0] = 1'b0;

  // Once a lane reports an error the rest of the beat is inert; the beat is then resolved as a whole.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic lane_en;
    assign lane_en = beat_ok & s_tkeep[gi] & ~err_c[gi];

    msg_byte_step #(.MAX_MSG_BYTES(MAX_MSG_BYTES)) u_step (
      .en_i    (lane_en),
      .byte_i  (s_tdata[gi*BYTE_W +: BYTE_W]),
      .state_i (st_c[gi]),
      .cnt_i   (cnt_c[gi]),
      .len_i   (len_c[gi]),
      .idx_i   (idx_c[gi]),
      .state_o (st_c[gi+1]),
      .cnt_o   (cnt_c[gi+1]),
      .len_o   (len_c[gi+1]),
      .idx_o   (idx_c[gi+1]),
      .err_o   (step_err[gi]),
      .wr_o    (wr_c[gi]),
      .clr_o   (clr_c[gi]),
      .done_o  (done_c[gi])
    );

    assign err_c[gi+1] = err_c[gi] | step_err[gi];
  end

  logic          done_any, beat_err;
  logic [DW-1:0] snap_data;
  logic [15:0]   snap_len;

  always_comb begin
    buf_d        = buf_q;
    snap_data    = msg_data_q;
    snap_len     = msg_length_q;
    done_any     = 1'b0;
    beat_err     = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    idx_d        = idx_q;
    msg_valid_d  = 1'b0;
    msg_error_d  = 1'b0;
    msg_length_d = msg_length_q;
    msg_data_d   = msg_data_q;

    // Snapshot at completion, since a later lane may start the next record and clear the buffer.
    for (int k = 0; k < LANES; k++) begin
      if (clr_c[k]) buf_d = '0;
      if (wr_c[k] && int'(idx_c[k]) < MAX_MSG_BYTES)
        buf_d[int'(idx_c[k])*BYTE_W +: BYTE_W] = s_tdata[k*BYTE_W +: BYTE_W];
      if (done_c[k]) begin
        done_any  = 1'b1;
        snap_data = buf_d;
        snap_len  = len_c[k];
      end
    end

    if (beat_ok) begin
      if (state_q == ST_DRAIN) begin
        if (s_tlast) state_d = ST_CNT_LO;
      end else begin
        beat_err = s_tuser | err_c[LANES] | (s_tlast != (st_c[LANES] == ST_DONE));
        cnt_d    = cnt_c[LANES];
        len_d    = len_c[LANES];
        idx_d    = idx_c[LANES];
        if (beat_err) begin
          msg_error_d = 1'b1;
          state_d     = s_tlast ? ST_CNT_LO : ST_DRAIN;
        end else begin
          state_d = s_tlast ? ST_CNT_LO : st_c[LANES];
          if (done_any) begin
            msg_valid_d  = 1'b1;
            msg_length_d = snap_len;
            msg_data_d   = snap_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_CNT_LO;
      cnt_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      buf_q        <= '0;
      msg_valid_q  <= 1'b0;
      msg_error_q  <= 1'b0;
      msg_length_q <= '0;
      msg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      msg_valid_q  <= msg_valid_d;
      msg_error_q  <= msg_error_d;
      msg_length_q <= msg_length_d;
      msg_data_q   <= msg_data_d;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_error  = msg_error_q;
  assign msg_length = msg_length_q;
  assign msg_data   = msg_data_q;

endmodule

// File: tb/tb_msg_parser.sv
// Self-checking bench for msg_parser: directed packets plus randomized packets with injected faults.
module tb_msg_parser;

  localparam int MAXB = 32;
  localparam int DW   = MAXB * 8;
  typedef logic [DW-1:0] word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        msg_valid, msg_error;
  logic [15:0] msg_length;
  word_t       msg_data;

  always #5 clk = ~clk;

  msg_parser #(.MAX_MSG_BYTES(MAXB), .TDATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .msg_valid  (msg_valid),
    .msg_length (msg_length),
    .msg_data   (msg_data),
    .msg_error  (msg_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected output events in order: messages and error pulses.
  typedef struct {
    bit    is_err;
    int    len;
    word_t data;
  } ev_t;

  ev_t          exp_q[$];
  byte unsigned pkt[$];
  int           comp_pos[$];
  ev_t          msgs[$];
  int           err_pos;

  // Scoreboard: every output pulse must match the next expected event.
  ev_t mon_e;
  always @(negedge clk) begin
    if (msg_error || msg_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", word_t'({msg_valid, msg_error}), word_t'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("msg_is_error", word_t'(msg_error), word_t'(mon_e.is_err));
        if (!mon_e.is_err) begin
          check("msg_length", word_t'(msg_length), word_t'(mon_e.len));
          check("msg_data", msg_data, mon_e.data);
        end
      end
    end
  end

  // Builds a packet; record bad_idx (if >= 0) gets bad_len in its length field.
  task automatic build(input int lens[$], input int bad_idx, input int bad_len);
    pkt.delete();
    comp_pos.delete();
    msgs.delete();
    err_pos = -1;
    pkt.push_back(8'(lens.size()));
    pkt.push_back(8'(lens.size() >> 8));
    foreach (lens[j]) begin
      int  fld;
      ev_t m;
      fld = (j == bad_idx) ? bad_len : lens[j];
      pkt.push_back(fld[7:0]);
      pkt.push_back(fld[15:8]);
      if (j == bad_idx) err_pos = pkt.size() - 1;
      m.is_err = 1'b0;
      m.len    = lens[j];
      m.data   = '0;
      for (int i = 0; i < lens[j]; i++) begin
        byte unsigned v;
        v = 8'($urandom);
        pkt.push_back(v);
        m.data[i*8 +: 8] = v;
      end
      if (j != bad_idx) begin
        comp_pos.push_back(pkt.size() - 1);
        msgs.push_back(m);
      end
    end
  endtask

  // Messages finishing in a beat before the error beat survive; the error beat suppresses its own.
  task automatic queue_expect(input int e);
    ev_t x;
    foreach (msgs[i])
      if (e < 0 || comp_pos[i] / 8 < e) exp_q.push_back(msgs[i]);
    if (e >= 0) begin
      x.is_err = 1'b1;
      x.len    = 0;
      x.data   = '0;
      exp_q.push_back(x);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tdata  = {$urandom, $urandom};
    s_tkeep  = 8'($urandom);
    s_tlast  = 1'($urandom);
    s_tuser  = 1'($urandom);
  endtask

  task automatic drive_beat(input int b, input bit last, input bit user);
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom};
    s_tkeep  = '0;
    for (int l = 0; l < 8; l++) begin
      if (b * 8 + l < pkt.size()) begin
        s_tdata[l*8 +: 8] = pkt[b*8+l];
        s_tkeep[l]        = 1'b1;
      end
    end
    s_tlast = last;
    s_tuser = user;
  endtask

  task automatic send_pkt(input int user_beat);
    int nb;
    nb = (pkt.size() + 7) / 8;
    $display("pkt bytes=%0d beats=%0d tuser_beat=%0d queued_events=%0d", pkt.size(), nb, user_beat, exp_q.size());
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 1)) idle_cycle();
      drive_beat(b, b == nb - 1, b == user_beat);
    end
    idle_cycle();
  endtask

  task automatic load_words(input logic [63:0] w[$], input int nbytes);
    logic [63:0] cur;
    pkt.delete();
    for (int i = 0; i < nbytes; i++) begin
      cur = w[i/8];
      pkt.push_back(cur[(i%8)*8 +: 8]);
    end
  endtask

  task automatic push_msg(input int len, input word_t data);
    ev_t x;
    x.is_err = 1'b0;
    x.len    = len;
    x.data   = data;
    exp_q.push_back(x);
  endtask

  task automatic check_reset_outputs();
    check("rst_tready", word_t'(s_tready), word_t'(0));
    check("rst_msg_valid", word_t'(msg_valid), word_t'(0));
    check("rst_msg_error", word_t'(msg_error), word_t'(0));
    check("rst_msg_length", word_t'(msg_length), word_t'(0));
    check("rst_msg_data", msg_data, word_t'(0));
  endtask

  task automatic run_directed();
    logic [63:0] w[$];
    int          lens[$];
    int          l33[8] = '{8, 12, 10, 15, 14, 17, 11, 8};

    w.delete();
    w.push_back(64'habcddcef00080001);
    w.push_back(64'h00000000630d658d);
    load_words(w, 12);
    push_msg(8, word_t'(64'h630d658dabcddcef));
    send_pkt(-1);

    w.delete();
    w.push_back(64'h045de506000e0002);
    w.push_back(64'h0388956084130858);
    w.push_back(64'h854680520008a5b0);
    w.push_back(64'h00000000d845a30c);
    load_words(w, 28);
    push_msg(14, word_t'(112'ha5b00388956084130858045de506));
    push_msg(8, word_t'(64'hd845a30c85468052));
    send_pkt(-1);

    lens.delete();
    lens.push_back(10); lens.push_back(9);
    build(lens, 0, 5);
    queue_expect(err_pos / 8);
    send_pkt(-1);

    lens.delete();
    lens.push_back(9);
    build(lens, 0, 33);
    queue_expect(err_pos / 8);
    send_pkt(-1);

    lens.delete();
    lens.push_back(20); lens.push_back(20);
    build(lens, -1, 0);
    queue_expect(2);
    send_pkt(2);

    lens.delete();
    foreach (l33[i]) lens.push_back(l33[i]);
    build(lens, -1, 0);
    queue_expect(-1);
    send_pkt(-1);
  endtask

  // kind: 0 clean, 1 tuser, 2 bad length, 3 zero count, 4 early tlast, 5 trailing bytes
  task automatic run_random(input int iters);
    for (int t = 0; t < iters; t++) begin
      int kind, n, e, ub, bad, badl, s;
      int lens[$];
      kind = t % 6;
      n    = $urandom_range(1, 4);
      e    = -1;
      ub   = -1;
      bad  = -1;
      badl = 0;
      for (int j = 0; j < n; j++) lens.push_back($urandom_range(8, MAXB));
      if (kind == 2) begin
        bad  = $urandom_range(0, n - 1);
        badl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(MAXB + 1, 600);
      end
      build(lens, bad, badl);
      case (kind)
        1: begin
          ub = $urandom_range(0, (pkt.size() + 7) / 8 - 1);
          e  = ub;
        end
        2: e = err_pos / 8;
        3: begin
          pkt.delete();
          msgs.delete();
          comp_pos.delete();
          pkt.push_back(8'h00);
          pkt.push_back(8'h00);
          repeat ($urandom_range(0, 20)) pkt.push_back(8'($urandom));
          e = 0;
        end
        4: begin
          s = $urandom_range(1, pkt.size() - 1);
          while (pkt.size() > s) void'(pkt.pop_back());
          e = (s - 1) / 8;
        end
        5: begin
          e = comp_pos[comp_pos.size()-1] / 8;
          repeat ($urandom_range(1, 12)) pkt.push_back(8'($urandom));
        end
        default: ;
      endcase
      queue_expect(e);
      send_pkt(ub);
    end
  endtask

  task automatic run_reset_mid_packet();
    int lens[$];
    lens.push_back(20);
    build(lens, -1, 0);
    drive_beat(0, 1'b0, 1'b0);
    @(negedge clk);
    s_tvalid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    lens.delete();
    lens.push_back(9); lens.push_back(16);
    build(lens, -1, 0);
    queue_expect(-1);
    send_pkt(-1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    check("tready_after_reset", word_t'(s_tready), word_t'(1));

    run_directed();
    run_random(60);
    run_directed();
    repeat (4) @(negedge clk);
    run_reset_mid_packet();

    repeat (10) @(negedge clk);
    check("pending_events", word_t'(exp_q.size()), word_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
